// File: rtl/sr_flop_bank.sv
// rtl/sr_flop_bank.sv - parametrised synchronous set/reset flop bank with illegal-input tracking
//
// Purpose: WIDTH independent S/R bits updated on the rising clk edge while en
// is high. The S=R=1 response is chosen by MODE. Per channel, the bank also
// reports a one-cycle change pulse and a sticky illegal-input flag. A shared
// saturating counter accumulates illegal channel-events.
//
// Ports:
//   clk      in   clock, all state updates on rising edge
//   rst_n    in   synchronous active-low reset
//   en       in   gate, S/R sampled only when high
//   S, R     in   [WIDTH] per-channel set / reset requests
//   clr_err  in   synchronous clear of err and err_cnt
//   q        out  [WIDTH] registered channel state
//   q_n      out  [WIDTH] combinational complement of q
//   changed  out  [WIDTH] one-cycle pulse when the channel changed on this edge
//   err      out  [WIDTH] sticky S=R=1-while-enabled flag
//   err_cnt  out  [ERR_CNT_W] saturating illegal-event count
module sr_flop_bank #(
  parameter int unsigned             WIDTH     = 4,
  parameter int unsigned             MODE      = 0,
  parameter logic [WIDTH-1:0]        INIT      = '0,
  parameter int unsigned             ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     S,
  input  logic [WIDTH-1:0]     R,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     q_n,
  output logic [WIDTH-1:0]     changed,
  output logic [WIDTH-1:0]     err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Sum is wide enough for max count plus up to 32 events without overflow.
  localparam int unsigned SUM_W = ERR_CNT_W + 7;
  localparam logic [SUM_W-1:0] CNT_MAX = {{7{1'b0}}, {ERR_CNT_W{1'b1}}};

  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     changed_q, changed_d;
  logic [WIDTH-1:0]     err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     ill;
  logic [6:0]           ill_pop;
  logic [SUM_W-1:0]     cnt_sum;

  assign ill = en ? (S & R) : '0;

  always_comb begin
    ill_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ill_pop = ill_pop + {6'd0, ill[i]};
    end
  end

  always_comb begin
    q_d = q_q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({S[i], R[i]})
          2'b10:   q_d[i] = 1'b1;
          2'b01:   q_d[i] = 1'b0;
          2'b11: begin
            case (MODE)
              1:       q_d[i] = 1'b1;
              2:       q_d[i] = 1'b0;
              3:       q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  assign changed_d = q_d ^ q_q;

  // A clear on the same edge as new events yields just this edge's events.
  always_comb begin
    err_d   = (clr_err ? '0 : err_q) | ill;
    cnt_sum = (clr_err ? '0 : {{7{1'b0}}, cnt_q}) + {{(SUM_W-7){1'b0}}, ill_pop};
    cnt_d   = (cnt_sum > CNT_MAX) ? CNT_MAX[ERR_CNT_W-1:0] : cnt_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q       <= INIT;
      changed_q <= '0;
      err_q     <= '0;
      cnt_q     <= '0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign q       = q_q;
  assign q_n     = ~q_q;
  assign changed = changed_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_sr_flop_bank.sv
// tb/tb_sr_flop_bank.sv - directed-vector bench for sr_flop_bank across modes and counter widths
module tb_sr_flop_bank;

  logic       clk = 1'b0;
  logic       rst_n, en, clr_err;
  logic [3:0] S, R;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] q0, qn0, ch0, er0;  logic [7:0] cnt0;
  logic [3:0] q1, qn1, ch1, er1;  logic [7:0] cnt1;
  logic [3:0] q2, qn2, ch2, er2;  logic [7:0] cnt2;
  logic [3:0] q3, qn3, ch3, er3;  logic [7:0] cnt3;
  logic [3:0] qs, qns, chs, ers;  logic [3:0] cnts;
  logic [3:0] qi, qni, chi, eri;  logic [7:0] cnti;

  always #5 clk = ~clk;

  sr_flop_bank #(.WIDTH(4), .MODE(0), .INIT(4'b0000), .ERR_CNT_W(8)) dut_m0 (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_err(clr_err),
    .q(q0), .q_n(qn0), .changed(ch0), .err(er0), .err_cnt(cnt0));
  sr_flop_bank #(.WIDTH(4), .MODE(1), .INIT(4'b0000), .ERR_CNT_W(8)) dut_m1 (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_err(clr_err),
    .q(q1), .q_n(qn1), .changed(ch1), .err(er1), .err_cnt(cnt1));
  sr_flop_bank #(.WIDTH(4), .MODE(2), .INIT(4'b0000), .ERR_CNT_W(8)) dut_m2 (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_err(clr_err),
    .q(q2), .q_n(qn2), .changed(ch2), .err(er2), .err_cnt(cnt2));
  sr_flop_bank #(.WIDTH(4), .MODE(3), .INIT(4'b0000), .ERR_CNT_W(8)) dut_m3 (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_err(clr_err),
    .q(q3), .q_n(qn3), .changed(ch3), .err(er3), .err_cnt(cnt3));
  sr_flop_bank #(.WIDTH(4), .MODE(0), .INIT(4'b0000), .ERR_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_err(clr_err),
    .q(qs), .q_n(qns), .changed(chs), .err(ers), .err_cnt(cnts));
  sr_flop_bank #(.WIDTH(4), .MODE(0), .INIT(4'b1010), .ERR_CNT_W(8)) dut_init (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_err(clr_err),
    .q(qi), .q_n(qni), .changed(chi), .err(eri), .err_cnt(cnti));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; S = 4'hF; R = 4'h0; clr_err = 1'b0;
    step(); step();
    vectors++; if (q0 !== 4'h0)   begin miscompares++; $display("FAIL reset_q got %h exp 0", q0); end
    vectors++; if (qn0 !== 4'hF)  begin miscompares++; $display("FAIL reset_qn got %h exp f", qn0); end
    vectors++; if (ch0 !== 4'h0)  begin miscompares++; $display("FAIL reset_changed got %h exp 0", ch0); end
    vectors++; if (er0 !== 4'h0)  begin miscompares++; $display("FAIL reset_err got %h exp 0", er0); end
    vectors++; if (cnt0 !== 8'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", cnt0); end
    vectors++; if (qi !== 4'b1010) begin miscompares++; $display("FAIL reset_init_q got %b exp 1010", qi); end
    vectors++; if (qni !== 4'b0101) begin miscompares++; $display("FAIL reset_init_qn got %b exp 0101", qni); end
  endtask

  task automatic test_set_reset();
    rst_n = 1'b1; en = 1'b1; S = 4'b0101; R = 4'b0000;
    step();
    vectors++; if (q0 !== 4'b0101)  begin miscompares++; $display("FAIL set_q got %b exp 0101", q0); end
    vectors++; if (qn0 !== 4'b1010) begin miscompares++; $display("FAIL set_qn got %b exp 1010", qn0); end
    vectors++; if (ch0 !== 4'b0101) begin miscompares++; $display("FAIL set_changed got %b exp 0101", ch0); end
    vectors++; if (chi !== 4'b0101) begin miscompares++; $display("FAIL set_init_changed got %b exp 0101", chi); end
    step();
    vectors++; if (q0 !== 4'b0101)  begin miscompares++; $display("FAIL reset_again_q got %b exp 0101", q0); end
    vectors++; if (ch0 !== 4'b0000) begin miscompares++; $display("FAIL set_again_changed got %b exp 0000", ch0); end
    S = 4'b0000; R = 4'b0001;
    step();
    vectors++; if (q0 !== 4'b0100)  begin miscompares++; $display("FAIL rst_q got %b exp 0100", q0); end
    vectors++; if (ch0 !== 4'b0001) begin miscompares++; $display("FAIL rst_changed got %b exp 0001", ch0); end
    R = 4'b0000;
    step();
    vectors++; if (ch0 !== 4'b0000) begin miscompares++; $display("FAIL changed_pulse got %b exp 0000", ch0); end
  endtask

  task automatic test_gate();
    en = 1'b0; S = 4'hF; R = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (q0 !== 4'b0100) begin miscompares++; $display("FAIL gate_q[%0d] got %b exp 0100", k, q0); end
      vectors++; if (ch0 !== 4'h0)   begin miscompares++; $display("FAIL gate_changed[%0d] got %b exp 0000", k, ch0); end
      vectors++; if (er0 !== 4'h0)   begin miscompares++; $display("FAIL gate_err[%0d] got %b exp 0000", k, er0); end
      vectors++; if (cnt0 !== 8'd0)  begin miscompares++; $display("FAIL gate_cnt[%0d] got %0d exp 0", k, cnt0); end
    end
  endtask

  task automatic test_modes();
    en = 1'b1; S = 4'b0011; R = 4'b1100;
    step();
    vectors++; if (q3 !== 4'b0011) begin miscompares++; $display("FAIL mode_pre_q got %b exp 0011", q3); end
    S = 4'hF; R = 4'hF;
    step();
    vectors++; if (q0 !== 4'b0011) begin miscompares++; $display("FAIL mode0_q got %b exp 0011", q0); end
    vectors++; if (q1 !== 4'b1111) begin miscompares++; $display("FAIL mode1_q got %b exp 1111", q1); end
    vectors++; if (q2 !== 4'b0000) begin miscompares++; $display("FAIL mode2_q got %b exp 0000", q2); end
    vectors++; if (q3 !== 4'b1100) begin miscompares++; $display("FAIL mode3_q got %b exp 1100", q3); end
    vectors++; if (ch0 !== 4'b0000) begin miscompares++; $display("FAIL mode0_changed got %b exp 0000", ch0); end
    vectors++; if (ch1 !== 4'b1100) begin miscompares++; $display("FAIL mode1_changed got %b exp 1100", ch1); end
    vectors++; if (ch2 !== 4'b0011) begin miscompares++; $display("FAIL mode2_changed got %b exp 0011", ch2); end
    vectors++; if (ch3 !== 4'b1111) begin miscompares++; $display("FAIL mode3_changed got %b exp 1111", ch3); end
    vectors++; if (er0 !== 4'hF || er1 !== 4'hF || er2 !== 4'hF || er3 !== 4'hF)
      begin miscompares++; $display("FAIL mode_err got %h %h %h %h exp f f f f", er0, er1, er2, er3); end
    vectors++; if (cnt0 !== 8'd4 || cnt1 !== 8'd4 || cnt2 !== 8'd4 || cnt3 !== 8'd4)
      begin miscompares++; $display("FAIL mode_cnt got %0d %0d %0d %0d exp 4 4 4 4", cnt0, cnt1, cnt2, cnt3); end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_s [5];
    logic [7:0] exp_w [5];
    exp_s[0] = 4'd4;  exp_s[1] = 4'd8;  exp_s[2] = 4'd12; exp_s[3] = 4'd15; exp_s[4] = 4'd15;
    exp_w[0] = 8'd4;  exp_w[1] = 8'd8;  exp_w[2] = 8'd12; exp_w[3] = 8'd16; exp_w[4] = 8'd20;
    // Clear while gated: clr_err still acts, S=R=1 ignored.
    en = 1'b0; clr_err = 1'b1; S = 4'hF; R = 4'hF;
    step();
    vectors++; if (er0 !== 4'h0 || cnt0 !== 8'd0) begin miscompares++; $display("FAIL gated_clr got err %h cnt %0d exp 0 0", er0, cnt0); end
    clr_err = 1'b0; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++; if (cnts !== exp_s[k]) begin miscompares++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", k, cnts, exp_s[k]); end
      vectors++; if (cnt0 !== exp_w[k]) begin miscompares++; $display("FAIL wide_cnt[%0d] got %0d exp %0d", k, cnt0, exp_w[k]); end
    end
    clr_err = 1'b1; S = 4'b0011; R = 4'b0011;
    step();
    vectors++; if (ers !== 4'b0011) begin miscompares++; $display("FAIL clr_evt_err got %b exp 0011", ers); end
    vectors++; if (cnts !== 4'd2)   begin miscompares++; $display("FAIL clr_evt_cnt got %0d exp 2", cnts); end
    S = 4'b0000; R = 4'b0000;
    step();
    vectors++; if (ers !== 4'b0000) begin miscompares++; $display("FAIL clr_err got %b exp 0000", ers); end
    vectors++; if (cnts !== 4'd0)   begin miscompares++; $display("FAIL clr_cnt got %0d exp 0", cnts); end
    clr_err = 1'b0;
  endtask

  task automatic test_midrun_reset();
    en = 1'b1; S = 4'b0101; R = 4'b1010;
    step();
    S = 4'b0011; R = 4'b0011;
    step();
    vectors++; if (qi !== 4'b0101 || eri !== 4'h3 || cnti !== 8'd2)
      begin miscompares++; $display("FAIL mid_pre got q %b err %h cnt %0d exp 0101 3 2", qi, eri, cnti); end
    rst_n = 1'b0; S = 4'hF; R = 4'h0; clr_err = 1'b0;
    step();
    vectors++; if (qi !== 4'b1010)  begin miscompares++; $display("FAIL mid_q got %b exp 1010", qi); end
    vectors++; if (eri !== 4'h0)    begin miscompares++; $display("FAIL mid_err got %h exp 0", eri); end
    vectors++; if (cnti !== 8'd0)   begin miscompares++; $display("FAIL mid_cnt got %0d exp 0", cnti); end
    vectors++; if (chi !== 4'h0)    begin miscompares++; $display("FAIL mid_changed got %b exp 0000", chi); end
    rst_n = 1'b1; S = 4'b0001; R = 4'b0000;
    step();
    vectors++; if (qi !== 4'b1011)  begin miscompares++; $display("FAIL resume_q got %b exp 1011", qi); end
    vectors++; if (chi !== 4'b0001) begin miscompares++; $display("FAIL resume_changed got %b exp 0001", chi); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; S = 4'h0; R = 4'h0; clr_err = 1'b0;
    test_reset();
    test_set_reset();
    test_gate();
    test_modes();
    test_saturate();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Parametrised, fully synchronous successor to the gated RS latch.
- Holds WIDTH independent set/reset bits, updated on the rising clk edge while the gate input en is high.
- The S=R=1 response is selectable at build time (hold, set-dominant, reset-dominant or toggle).
- Each channel also produces a change-event pulse, a sticky illegal-input flag and a shared saturating illegal-event counter, for status and debug logic in the lab designs.

Parameters:
WIDTH, 4, number of independent channels (1..32)
MODE, 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
INIT, 0, WIDTH-bit reset value loaded into q
ERR_CNT_W, 8, width of err_cnt (2..16)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
en  input  1  gate; S/R sampled only when en=1
S  input  WIDTH  per-channel set request
R  input  WIDTH  per-channel reset request
clr_err  input  1  clears err and err_cnt (synchronous)
q  output  WIDTH  registered channel state
q_n  output  WIDTH  combinational ~q, always the exact complement
changed  output  WIDTH  registered one-cycle pulse: channel q changed on this edge
err  output  WIDTH  sticky flag: channel saw S=R=1 while en=1
err_cnt  output  ERR_CNT_W  saturating count of illegal channel-events

Behaviour:
- Reset: clk edge with rst_n=0 sets q=INIT, changed=0, err=0 and err_cnt=0. Reset overrides en, S, R and clr_err, and may be asserted mid-operation; the next edge after release behaves normally.
- Latency: S/R sampled on edge k appear on q after edge k (one cycle). q_n tracks q combinationally.
- en=0: q holds, changed=0, err and err_cnt unaffected by S/R. clr_err still acts.
- en=1, per channel i:
  - S=0, R=0: q holds.
  - S=1, R=0: q becomes 1.
  - S=0, R=1: q becomes 0.
  - S=1, R=1: MODE 0 holds, 1 sets to 1, 2 resets to 0, 3 inverts q.
- Illegal event: en=1 and S[i]=R[i]=1. This is flagged in every MODE, including toggle.
- changed[i]: registered on the same edge as q, equal to (q_next[i] != q[i]). It is high for exactly one cycle per transition. A set on an already-set channel gives changed=0.
- err[i]: set on any illegal event on channel i and stays high until clr_err or reset.
- err_cnt:
  - Each edge adds the popcount of illegal events across all channels on that edge (0..WIDTH).
  - Saturates at 2^ERR_CNT_W-1 and never wraps. A partial add that would exceed max clamps to max.
- clr_err:
  - With no event on the same edge: err=0 and err_cnt=0.
  - With an event on the same edge, the new event wins: err equals that edge's event mask and err_cnt equals that edge's popcount, clamped.
- No combinational path from S, R or en to q, changed, err or err_cnt.
- MODE values outside 0..3 behave as MODE 0.

Test Plan:
- WIDTH=4, MODE=0, INIT=0. Hold rst_n=0 for 2 edges while S=4'hF, en=1 -> q=0, q_n=4'hF, changed=0, err=0, err_cnt=0.
- en=1, S=4'b0101, R=0 for one edge -> q=4'b0101, changed=4'b0101 for one cycle. Repeat the same S -> changed=0. Then R=4'b0001 -> q=4'b0100, changed=4'b0001.
- en=0, S=4'hF, R=4'hF for 3 edges -> q unchanged, changed=0, err=0, err_cnt=0.
- Sweep MODE 0/1/2/3 from q=4'b0011 with S=R=4'hF for one edge -> q=4'b0011 / 4'hF / 4'h0 / 4'b1100. In all modes err=4'hF, err_cnt=4.
- ERR_CNT_W=4, S=R=4'hF, en=1 for 5 edges -> err_cnt goes 4, 8, 12, 15, 15 (saturates). Then clr_err=1 with S=R=4'b0011 -> err=4'b0011, err_cnt=2. Then clr_err=1 with S=R=0 -> err=0, err_cnt=0.
- Mid-run reset with INIT=4'b1010: q=4'b0101, err=4'h3, then rst_n=0 for one edge with S=4'hF -> q=4'b1010, err=0, err_cnt=0, changed=0. Normal updates resume on the next edge.
